// File: rtl/alu_pkg.sv
// Shared ALU definitions: logic-unit opcode encoding and its width.
package alu_pkg;

  localparam int unsigned LOGIC_OP_W = 3;

  typedef enum logic [LOGIC_OP_W-1:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_XOR   = 3'b010,
    OP_NOR   = 3'b011,
    OP_ANDN  = 3'b100,
    OP_ORN   = 3'b101,
    OP_PASSA = 3'b110,
    OP_PASSB = 3'b111
  } logic_op_t;

endpackage

// File: rtl/logic_unit_comb.sv
// Combinational bitwise op decode with zero detect; bit i of the result
// depends only on bit i of the operands.
module logic_unit_comb
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [LOGIC_OP_W-1:0] op_i,
  input  logic [WIDTH-1:0]      a_i,
  input  logic [WIDTH-1:0]      b_i,
  output logic [WIDTH-1:0]      res_c,
  output logic                  zero_c
);

  always_comb begin
    res_c = '0;
    case (logic_op_t'(op_i))
      OP_AND:   res_c = a_i & b_i;
      OP_OR:    res_c = a_i | b_i;
      OP_XOR:   res_c = a_i ^ b_i;
      OP_NOR:   res_c = ~(a_i | b_i);
      OP_ANDN:  res_c = a_i & ~b_i;
      OP_ORN:   res_c = a_i | ~b_i;
      OP_PASSA: res_c = a_i;
      OP_PASSB: res_c = b_i;
      default:  res_c = '0;
    endcase
    zero_c = ~|res_c;
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: valid/ready on both ends, bubble-collapsing
// register chain carrying result, zero flag and tag, with synchronous flush.
module logic_unit_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LOGIC_OP_W-1:0] in_op,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic [TAG_W-1:0]      in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_res,
  output logic                  out_zero,
  output logic [TAG_W-1:0]      out_tag
);

  localparam int unsigned LAST = STAGES - 1;

  logic             vld_q  [STAGES];
  logic [WIDTH-1:0] res_q  [STAGES];
  logic             zero_q [STAGES];
  logic [TAG_W-1:0] tag_q  [STAGES];

  logic [STAGES-1:0] adv_c;
  logic              accept_c;
  logic [WIDTH-1:0]  res_c;
  logic              zero_c;

  logic_unit_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .op_i   (in_op),
    .a_i    (in_a),
    .b_i    (in_b),
    .res_c  (res_c),
    .zero_c (zero_c)
  );

  // A stage advances when empty or when its contents move on; resolved back to front.
  always_comb begin
    adv_c = '0;
    adv_c[LAST] = !vld_q[LAST] || out_ready;
    for (int i = int'(LAST) - 1; i >= 0; i--) begin
      adv_c[i] = !vld_q[i] || adv_c[i+1];
    end
  end

  assign in_ready = adv_c[0] && !flush;
  assign accept_c = in_valid && in_ready;

  for (genvar g = 0; g < int'(STAGES); g++) begin : g_stage
    if (g == 0) begin : g_head
      // Head stage captures the computed result; data only loads on accept.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q[0]  <= 1'b0;
          res_q[0]  <= '0;
          zero_q[0] <= 1'b0;
          tag_q[0]  <= '0;
        end else begin
          if (flush) begin
            vld_q[0] <= 1'b0;
          end else if (adv_c[0]) begin
            vld_q[0] <= in_valid;
          end
          if (accept_c) begin
            res_q[0]  <= res_c;
            zero_q[0] <= zero_c;
            tag_q[0]  <= in_tag;
          end
        end
      end
    end else begin : g_body
      // Move-only stage; an empty upstream stage propagates as a bubble.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q[g]  <= 1'b0;
          res_q[g]  <= '0;
          zero_q[g] <= 1'b0;
          tag_q[g]  <= '0;
        end else begin
          if (flush) begin
            vld_q[g] <= 1'b0;
          end else if (adv_c[g]) begin
            vld_q[g] <= vld_q[g-1];
          end
          if (!flush && adv_c[g] && vld_q[g-1]) begin
            res_q[g]  <= res_q[g-1];
            zero_q[g] <= zero_q[g-1];
            tag_q[g]  <= tag_q[g-1];
          end
        end
      end
    end
  end

  assign out_valid = vld_q[LAST];
  assign out_res   = res_q[LAST];
  assign out_zero  = zero_q[LAST];
  assign out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: latency, all ops, stall, flush and async reset.
module tb_logic_unit_pipe;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 2;
  localparam int unsigned TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res;
  logic             out_zero;
  logic [TAG_W-1:0] out_tag;

  logic_unit_pipe #(
    .WIDTH  (WIDTH),
    .STAGES (STAGES),
    .TAG_W  (TAG_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  int   out_cyc[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_acc    = 0;
  int   cyc      = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a ^ b;
      3'b011:  return ~(a | b);
      3'b100:  return a & ~b;
      3'b101:  return a | ~b;
      3'b110:  return a;
      default: return b;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: push on accept, pop on transfer; flush or reset empties it.
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        out_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check_val("unexpected_out", 64'(out_tag), 64'h3f);
        end else begin
          e_mon = sb.pop_front();
          check_val("res", 64'(out_res), 64'(e_mon.res));
          check_val("zero", 64'(out_zero), 64'(e_mon.zero));
          check_val("tag", 64'(out_tag), 64'(e_mon.tag));
        end
      end
      if (in_valid && in_ready) begin
        n_acc++;
        e_mon.res  = model(in_op, in_a, in_b);
        e_mon.zero = (e_mon.res == '0);
        e_mon.tag  = in_tag;
        sb.push_back(e_mon);
      end
    end
  end

  // Present a request from posedge+1 and hold it until accepted.
  task automatic send(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [TAG_W-1:0] tag);
    bit acc;
    int budget;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_tag = tag;
    acc = 1'b0; budget = 0;
    while (!acc) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      budget++;
      if (!acc && budget > 200) begin
        check_val("send_timeout", 64'(budget), 64'd0);
        acc = 1'b1;
      end
    end
  endtask

  task automatic go_idle();
    in_valid = 1'b0;
    in_op    = 3'bxxx;
  endtask

  task automatic check_latency(input string tag);
    for (int k = 1; k < int'(STAGES); k++) begin
      check_val("lat_early", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    check_val(tag, 64'(out_valid), 64'd1);
  endtask

  task automatic drain();
    int budget;
    go_idle();
    out_ready = 1'b1;
    budget = 0;
    while ((sb.size() != 0 || out_valid) && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 100) check_val("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int c0, base, tr0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_out_valid", 64'(out_valid), 64'd0);
    check_val("rst_out_res", 64'(out_res), 64'd0);
    check_val("rst_out_zero", 64'(out_zero), 64'd0);
    check_val("rst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("rst_in_ready", 64'(in_ready), 64'd1);

    // Single request latency and value
    send(3'b001, 32'h0F0F_0000, 32'h0000_00F0, 5'd3);
    go_idle();
    check_latency("lat_first");
    check_val("t1_res", 64'(out_res), 64'h0F0F_00F0);
    check_val("t1_zero", 64'(out_zero), 64'd0);
    check_val("t1_tag", 64'(out_tag), 64'd3);
    drain();

    // All eight ops back to back, one per cycle
    out_cyc.delete();
    c0 = cyc;
    for (int op = 0; op < 8; op++) send(3'(op), 32'hFFFF_0000, 32'hFF00_FF00, 5'(8 + op));
    go_idle();
    check_val("burst_accept_cycles", 64'(cyc - c0), 64'd8);
    drain();
    check_val("burst_out_count", 64'(out_cyc.size()), 64'd8);
    for (int i = 1; i < out_cyc.size(); i++)
      check_val("burst_out_gap", 64'(out_cyc[i] - out_cyc[i-1]), 64'd1);

    // XOR of equal operands gives zero
    send(3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5'd1);
    go_idle();
    check_latency("lat_xor");
    check_val("xor_res", 64'(out_res), 64'd0);
    check_val("xor_zero", 64'(out_zero), 64'd1);
    drain();

    // Back-pressure: pipe fills to STAGES entries then stalls stable
    base = n_acc;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 4; k++) send(3'b110, 32'h1000 + 32'(k), 32'h0, 5'(20 + k));
        go_idle();
      end
      begin
        repeat (2) @(posedge clk);
        repeat (4) begin
          @(negedge clk);
          check_val("stall_in_ready", 64'(in_ready), 64'd0);
          check_val("stall_out_valid", 64'(out_valid), 64'd1);
          if (sb.size() != 0) begin
            check_val("stall_res", 64'(out_res), 64'(sb[0].res));
            check_val("stall_tag", 64'(out_tag), 64'(sb[0].tag));
          end else begin
            check_val("stall_sb_size", 64'(sb.size()), 64'(STAGES));
          end
        end
        check_val("stall_accepts", 64'(n_acc - base), 64'(STAGES));
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_val("stall_total_accepts", 64'(n_acc - base), 64'd4);

    // Flush with two in flight and a concurrent request
    send(3'b001, 32'h0000_0011, 32'h0000_2200, 5'd10);
    send(3'b000, 32'hFFFF_FFFF, 32'h0000_0F00, 5'd11);
    flush = 1'b1;
    in_valid = 1'b1; in_op = 3'b110; in_a = 32'h5A5A_5A5A; in_b = '0; in_tag = 5'd30;
    @(negedge clk);
    check_val("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    go_idle();
    check_val("flush_out_valid", 64'(out_valid), 64'd0);
    tr0 = out_cyc.size();
    repeat (5) @(posedge clk);
    #1;
    check_val("flush_no_output", 64'(out_cyc.size() - tr0), 64'd0);
    send(3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd12);
    go_idle();
    check_latency("lat_after_flush");
    drain();

    // Asynchronous reset between edges, mid-stream
    in_valid = 1'b1; in_op = 3'b001; in_a = 32'h00AA_0000; in_b = 32'h5; in_tag = 5'd7;
    @(posedge clk); #1;
    in_a = 32'h00BB_0000; in_tag = 5'd8;
    @(posedge clk); #1;
    in_a = 32'h00CC_0000; in_tag = 5'd9;
    @(posedge clk); #3;
    check_val("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    go_idle();
    #1;
    check_val("arst_out_valid", 64'(out_valid), 64'd0);
    check_val("arst_out_res", 64'(out_res), 64'd0);
    check_val("arst_out_zero", 64'(out_zero), 64'd0);
    check_val("arst_out_tag", 64'(out_tag), 64'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_in_ready", 64'(in_ready), 64'd1);
    check_val("post_rst_out_valid", 64'(out_valid), 64'd0);
    send(3'b011, 32'h0000_FFFF, 32'h00FF_0000, 5'd15);
    go_idle();
    check_latency("lat_after_reset");
    drain();

    check_val("sb_empty", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
